// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller command port between the LCD frame reader
//   (burst reads, high priority) and the Julia pixel writer (single-beat
//   writes). Read data is returned to the reader one cycle after the
//   controller presents it. The number of read beats in flight is bounded,
//   and a starvation limit guarantees the writer forward progress.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   rd_req/rd_addr/rd_len        reader request (held until rd_gnt)
//   rd_gnt                       1-cycle pulse: read command accepted
//   rd_data/rd_valid             returned read data, one pulse per beat
//   wr_req/wr_addr/wr_data       writer request (held until wr_gnt)
//   wr_gnt                       1-cycle pulse: write command accepted
//   m_addr/m_read/m_write        controller command
//   m_wdata/m_burstcount         controller write data / burst length
//   m_waitrequest                controller stall, command held while high
//   m_rdata/m_rdvalid            controller read return
//   err_underflow                sticky: read beat returned with none outstanding
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W          = 22,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned BURST_W         = 4,
   parameter int unsigned STARVE_LIMIT    = 8,
   parameter int unsigned MAX_OUTSTANDING = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BURST_W-1:0] rd_len,
   output logic              rd_gnt,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_read,
   output logic              m_write,
   output logic [DATA_W-1:0] m_wdata,
   output logic [BURST_W-1:0] m_burstcount,
   input  logic              m_waitrequest,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rdvalid,
   output logic              err_underflow
);

   // Wide enough for outstanding plus a maximal new burst in the room check.
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + (1 << BURST_W) + 1);
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   outstanding_nxt;
   logic [STV_W-1:0]   starve_cnt;
   logic [BURST_W-1:0] len_eff;
   logic               room;
   logic               starve_ok;
   logic               pick_rd;
   logic               pick_wr;
   logic               rd_accept;
   logic               wr_accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      len_eff   = (rd_len == '0) ? BURST_W'(1) : rd_len;
      room      = (outstanding + OUT_W'(len_eff)) <= OUT_W'(MAX_OUTSTANDING);
      // Reads win unless the writer has been passed over STARVE_LIMIT times.
      starve_ok = (starve_cnt < STV_W'(STARVE_LIMIT)) || !wr_req;
      pick_rd   = 1'b0;
      pick_wr   = 1'b0;
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req && room && starve_ok) begin
               pick_rd   = 1'b1;
               state_nxt = RD_CMD;
            end else if (wr_req) begin
               pick_wr   = 1'b1;
               state_nxt = WR_CMD;
            end
         end
         RD_CMD: begin
            if (!m_waitrequest) begin
               rd_accept = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_CMD: begin
            if (!m_waitrequest) begin
               wr_accept = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      rd_gnt = rd_accept;
      wr_gnt = wr_accept;

      // Accept and a returning beat in the same cycle apply their net change;
      // a beat with nothing outstanding is flagged and never decrements.
      outstanding_nxt = outstanding;
      if (rd_accept) begin
         outstanding_nxt = outstanding_nxt + OUT_W'(m_burstcount);
      end
      if (m_rdvalid && (outstanding != '0)) begin
         outstanding_nxt = outstanding_nxt - OUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_addr        <= '0;
         m_read        <= 1'b0;
         m_write       <= 1'b0;
         m_wdata       <= '0;
         m_burstcount  <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         err_underflow <= 1'b0;
         outstanding   <= '0;
         starve_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         rd_data     <= m_rdata;
         rd_valid    <= m_rdvalid;
         if (m_rdvalid && (outstanding == '0)) begin
            err_underflow <= 1'b1;
         end

         if (pick_rd) begin
            m_read       <= 1'b1;
            m_addr       <= rd_addr;
            m_burstcount <= len_eff;
         end else if (pick_wr) begin
            m_write      <= 1'b1;
            m_addr       <= wr_addr;
            m_wdata      <= wr_data;
            m_burstcount <= BURST_W'(1);
         end
         if (rd_accept) begin
            m_read <= 1'b0;
         end
         if (wr_accept) begin
            m_write <= 1'b0;
         end

         if (rd_accept) begin
            if (!wr_req) begin
               starve_cnt <= '0;
            end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
               starve_cnt <= starve_cnt + STV_W'(1);
            end
         end else if (wr_accept) begin
            starve_cnt <= '0;
         end
      end
   end

endmodule
